// File: rtl/adc_ram_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : adc_ram_scheduler                                             |
// | Purpose  : Generates the ADC sample tick, queues EMG/ECG sample pairs in  |
// |            a small pending FIFO and drains each pair as two RAM writes   |
// |            into per-channel ring buffers during cycles the CPU leaves    |
// |            the shared data-RAM port idle. CPU accesses pass straight     |
// |            through and are never stalled.                                |
// | Options  : define ADC_SCHED_DROP_CNT_EN to build the saturating dropped- |
// |            tick counter; otherwise drop_count is tied to zero.          |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module adc_ram_scheduler #(
  parameter int          SAMPLE_INTERVAL = 175000,
  parameter logic [11:0] EMG_BASE        = 12'h800,
  parameter logic [11:0] ECG_BASE        = 12'hA00,
  parameter int          BUF_DEPTH       = 256,
  parameter int          FIFO_DEPTH      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wEn,
  input  logic [11:0] cpu_addr,
  input  logic [31:0] cpu_dataIn,
  input  logic [31:0] emg_in,
  input  logic [31:0] ecg_in,
  input  logic        clr_ovf,
  output logic        ram_wEn,
  output logic [11:0] ram_addr,
  output logic [31:0] ram_dataIn,
  output logic [15:0] wr_count,
  output logic        overflow,
  output logic [15:0] drop_count
);

  // Derived widths and constants
  localparam int c_timer_w = $clog2(SAMPLE_INTERVAL);
  localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w   = c_ptr_w + 1;

  localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(SAMPLE_INTERVAL - 1);
  localparam logic [c_timer_w-1:0] c_timer_one  = c_timer_w'(1);
  localparam logic [8:0]           c_idx_mask   = 9'(BUF_DEPTH - 1);
  localparam logic [c_ptr_w-1:0]   c_ptr_one    = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0]   c_cnt_one    = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0]   c_cnt_full   = c_cnt_w'(FIFO_DEPTH);

  // Drain sequencer: one lead-in cycle in IDLE, then EMG and ECG writes
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WR_EMG = 2'd1,
    S_WR_ECG = 2'd2
  } state_t;

  // Sample-rate timer and ring index
  logic [c_timer_w-1:0] r_timer;
  logic [8:0]           r_idx;
  logic                 w_tick;

  // Pending-pair FIFO storage and bookkeeping
  logic [31:0]          r_fifo_emg [FIFO_DEPTH];
  logic [31:0]          r_fifo_ecg [FIFO_DEPTH];
  logic [8:0]           r_fifo_idx [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_drop;

  // Head-of-queue view used by the port mux
  logic [31:0]          w_head_emg;
  logic [31:0]          w_head_ecg;
  logic [8:0]           w_head_idx;

  // Drain FSM and status registers
  state_t               r_state;
  logic [15:0]          r_wr_count;
  logic                 r_overflow;

  // Tick is the terminal-count cycle of the timer
  assign w_tick  = (r_timer == c_timer_last);

  // Fullness is judged on pre-edge occupancy; a same-cycle pop never rescues a tick
  assign w_full  = (r_count == c_cnt_full);
  assign w_empty = (r_count == '0);
  assign w_push  = w_tick & ~w_full;
  assign w_drop  = w_tick &  w_full;
  assign w_pop   = (r_state == S_WR_ECG) & ~cpu_req;

  assign w_head_emg = r_fifo_emg[r_rd_ptr];
  assign w_head_ecg = r_fifo_ecg[r_rd_ptr];
  assign w_head_idx = r_fifo_idx[r_rd_ptr];

  // Free-running sample timer, wraps after SAMPLE_INTERVAL cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + c_timer_one;
    end
  end

  // Ring index advances only when a pair is actually queued
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
    end else if (w_push) begin
      r_idx <= (r_idx + 9'd1) & c_idx_mask;
    end
  end

  // FIFO payload storage; contents are don't-care until pushed
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_emg[r_wr_ptr] <= emg_in;
      r_fifo_ecg[r_wr_ptr] <= ecg_in;
      r_fifo_idx[r_wr_ptr] <= r_idx;
    end
  end

  // FIFO pointers and occupancy; reset discards every pending entry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Drain FSM: writes only advance in cycles where the CPU leaves the port idle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wr_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state <= S_WR_EMG;
          end
        end
        S_WR_EMG: begin
          if (!cpu_req) begin
            r_state <= S_WR_ECG;
          end
        end
        S_WR_ECG: begin
          if (!cpu_req) begin
            r_state    <= S_IDLE;
            r_wr_count <= r_wr_count + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky overflow: a drop in the same cycle as clr_ovf keeps the flag set
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef ADC_SCHED_DROP_CNT_EN
  logic [15:0] r_drop_count;

  // Saturating count of ticks lost to a full FIFO
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign drop_count = r_drop_count;
`else
  assign drop_count = 16'd0;
`endif

  assign wr_count = r_wr_count;
  assign overflow = r_overflow;

  // Port mux: CPU always owns the port when it asks; otherwise the drain writes
  always_comb begin
    ram_wEn    = 1'b0;
    ram_addr   = cpu_addr;
    ram_dataIn = cpu_dataIn;
    if (cpu_req) begin
      ram_wEn    = cpu_wEn;
      ram_addr   = cpu_addr;
      ram_dataIn = cpu_dataIn;
    end else begin
      case (r_state)
        S_WR_EMG: begin
          ram_wEn    = 1'b1;
          ram_addr   = EMG_BASE + {3'b000, w_head_idx};
          ram_dataIn = w_head_emg;
        end
        S_WR_ECG: begin
          ram_wEn    = 1'b1;
          ram_addr   = ECG_BASE + {3'b000, w_head_idx};
          ram_dataIn = w_head_ecg;
        end
        default: begin
          ram_wEn    = 1'b0;
          ram_addr   = cpu_addr;
          ram_dataIn = cpu_dataIn;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_ram_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_adc_ram_scheduler                                          |
// | Purpose  : Self-checking bench for adc_ram_scheduler with a queue-based  |
// |            reference model and directed literal expectations.           |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_adc_ram_scheduler;

  localparam int SI = 8;
  localparam int BD = 4;
  localparam int FD = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_wEn = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [31:0] cpu_dataIn = '0;
  logic [31:0] emg_in = '0;
  logic [31:0] ecg_in = '0;
  logic        clr_ovf = 1'b0;
  logic        ram_wEn;
  logic [11:0] ram_addr;
  logic [31:0] ram_dataIn;
  logic [15:0] wr_count;
  logic        overflow;
  logic [15:0] drop_count;

  always #5 clock = ~clock;

  adc_ram_scheduler #(
    .SAMPLE_INTERVAL(SI),
    .EMG_BASE       (12'h800),
    .ECG_BASE       (12'hA00),
    .BUF_DEPTH      (BD),
    .FIFO_DEPTH     (FD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_wEn    (cpu_wEn),
    .cpu_addr   (cpu_addr),
    .cpu_dataIn (cpu_dataIn),
    .emg_in     (emg_in),
    .ecg_in     (ecg_in),
    .clr_ovf    (clr_ovf),
    .ram_wEn    (ram_wEn),
    .ram_addr   (ram_addr),
    .ram_dataIn (ram_dataIn),
    .wr_count   (wr_count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending pairs in a queue, drain progress of the head pair
  typedef struct {
    logic [31:0] emg;
    logic [31:0] ecg;
    int          idx;
  } pair_t;

  pair_t pend[$];
  int    m_cyc;
  int    m_next_idx;
  bit    m_head_live;
  int    m_head_writes;
  int    m_wr_count;
  int    m_drops;
  bit    m_ovf;

  always @(posedge clock or posedge reset) begin
    bit    was_full;
    bit    is_tick;
    pair_t p;
    if (reset) begin
      pend.delete();
      m_cyc         = 0;
      m_next_idx    = 0;
      m_head_live   = 0;
      m_head_writes = 0;
      m_wr_count    = 0;
      m_drops       = 0;
      m_ovf         = 0;
    end else begin
      was_full = (pend.size() == FD);
      is_tick  = ((m_cyc % SI) == SI - 1);
      if (!m_head_live) begin
        if (pend.size() > 0) m_head_live = 1;
      end else if (!cpu_req) begin
        if (m_head_writes == 0) begin
          m_head_writes = 1;
        end else begin
          void'(pend.pop_front());
          m_wr_count    = (m_wr_count + 1) % 65536;
          m_head_live   = 0;
          m_head_writes = 0;
        end
      end
      if (is_tick && !was_full) begin
        p.emg = emg_in;
        p.ecg = ecg_in;
        p.idx = m_next_idx;
        pend.push_back(p);
        m_next_idx = (m_next_idx + 1) % BD;
      end
      if (is_tick && was_full) begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end else if (clr_ovf) begin
        m_ovf = 0;
      end
      m_cyc++;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    logic        e_wen;
    logic [11:0] e_addr;
    logic [31:0] e_data;
    logic [15:0] e_drop;
    if (cpu_req) begin
      e_wen  = cpu_wEn;
      e_addr = cpu_addr;
      e_data = cpu_dataIn;
    end else if (m_head_live && pend.size() > 0) begin
      e_wen  = 1'b1;
      e_addr = (m_head_writes == 0 ? 12'h800 : 12'hA00) + 12'(pend[0].idx);
      e_data = (m_head_writes == 0) ? pend[0].emg : pend[0].ecg;
    end else begin
      e_wen  = 1'b0;
      e_addr = cpu_addr;
      e_data = cpu_dataIn;
    end
`ifdef ADC_SCHED_DROP_CNT_EN
    e_drop = 16'(m_drops);
`else
    e_drop = 16'd0;
`endif
    check("model ram_wEn",    {31'b0, ram_wEn},  {31'b0, e_wen});
    check("model ram_addr",   {20'b0, ram_addr}, {20'b0, e_addr});
    check("model ram_dataIn", ram_dataIn,        e_data);
    check("model wr_count",   {16'b0, wr_count}, 32'(m_wr_count % 65536));
    check("model overflow",   {31'b0, overflow}, {31'b0, m_ovf});
    check("model drop_count", {16'b0, drop_count}, {16'b0, e_drop});
  end

  // Stimulus: cycle 0 is the first cycle after reset release
  int cyc;

  task automatic next_cycle();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) next_cycle();
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    cpu_req    = 1'b0;
    cpu_wEn    = 1'b0;
    cpu_addr   = '0;
    cpu_dataIn = '0;
    clr_ovf    = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  logic [15:0] exp_drop1;

  initial begin
`ifdef ADC_SCHED_DROP_CNT_EN
    exp_drop1 = 16'd1;
`else
    exp_drop1 = 16'd0;
`endif
    cyc = 0;

    // Idle CPU: first tick at cycle 7, EMG write in 9, ECG in 10, count in 11
    do_reset();
    emg_in = 32'h111;
    ecg_in = 32'h222;
    #2;
    check("A reset wr_count", {16'b0, wr_count}, 32'd0);
    check("A reset overflow", {31'b0, overflow}, 32'd0);
    check("A reset ram_wEn",  {31'b0, ram_wEn},  32'd0);
    check("A reset drop",     {16'b0, drop_count}, 32'd0);
    run_to(8);  #2;
    check("A lead-in no write", {31'b0, ram_wEn}, 32'd0);
    run_to(9);  #2;
    check("A emg wEn",  {31'b0, ram_wEn},  32'd1);
    check("A emg addr", {20'b0, ram_addr}, 32'h800);
    check("A emg data", ram_dataIn,        32'h111);
    run_to(10); #2;
    check("A ecg addr", {20'b0, ram_addr}, 32'hA00);
    check("A ecg data", ram_dataIn,        32'h222);
    run_to(11); #2;
    check("A wr_count", {16'b0, wr_count}, 32'd1);

    // CPU holds the port for cycles 8..12; drain writes slip to 13 and 14
    do_reset();
    emg_in = 32'h333;
    ecg_in = 32'h444;
    run_to(8);
    cpu_req    = 1'b1;
    cpu_wEn    = 1'b1;
    cpu_addr   = 12'h010;
    cpu_dataIn = 32'hDEADBEEF;
    run_to(10); #2;
    check("B cpu wEn",  {31'b0, ram_wEn},  32'd1);
    check("B cpu addr", {20'b0, ram_addr}, 32'h010);
    check("B cpu data", ram_dataIn,        32'hDEADBEEF);
    run_to(13);
    cpu_req    = 1'b0;
    cpu_wEn    = 1'b0;
    cpu_addr   = 12'h000;
    cpu_dataIn = 32'h0;
    #2;
    check("B emg addr", {20'b0, ram_addr}, 32'h800);
    check("B emg data", ram_dataIn,        32'h333);
    run_to(14); #2;
    check("B ecg addr", {20'b0, ram_addr}, 32'hA00);
    check("B ecg data", ram_dataIn,        32'h444);

    // Five ticks with BUF_DEPTH=4: fifth pair wraps back to index 0
    do_reset();
    for (int c = 0; c <= 43; c++) begin
      run_to(c);
      emg_in = 32'h1000 + 32'(c);
      ecg_in = 32'h2000 + 32'(c);
      #2;
      if (c == 17) begin
        check("C second emg addr", {20'b0, ram_addr}, 32'h801);
        check("C second emg data", ram_dataIn,        32'h100F);
      end
      if (c == 41) begin
        check("C wrap emg addr", {20'b0, ram_addr}, 32'h800);
        check("C wrap emg data", ram_dataIn,        32'h1027);
      end
      if (c == 42) begin
        check("C wrap ecg addr", {20'b0, ram_addr}, 32'hA00);
        check("C wrap ecg data", ram_dataIn,        32'h2027);
      end
      if (c == 43) check("C wr_count", {16'b0, wr_count}, 32'd5);
    end

    // FIFO_DEPTH=2 with CPU busy: third tick drops; clr_ovf in the drop cycle loses
    do_reset();
    cpu_addr = 12'h123;
    for (int c = 0; c <= 33; c++) begin
      run_to(c);
      cpu_req = (c < 24);
      clr_ovf = (c == 23 || c == 30);
      emg_in  = 32'h5000 + 32'(c);
      ecg_in  = 32'h6000 + 32'(c);
      #2;
      if (c == 22) check("D overflow before drop", {31'b0, overflow}, 32'd0);
      if (c == 24) begin
        check("D overflow set wins", {31'b0, overflow},   32'd1);
        check("D drop_count",        {16'b0, drop_count}, {16'b0, exp_drop1});
        check("D first emg addr",    {20'b0, ram_addr},   32'h800);
        check("D first emg data",    ram_dataIn,          32'h5007);
      end
      if (c == 27) begin
        check("D second emg addr", {20'b0, ram_addr}, 32'h801);
        check("D second emg data", ram_dataIn,        32'h500F);
      end
      if (c == 29) check("D wr_count", {16'b0, wr_count}, 32'd2);
      if (c == 30) check("D overflow held", {31'b0, overflow}, 32'd1);
      if (c == 31) check("D overflow cleared", {31'b0, overflow}, 32'd0);
      if (c == 33) begin
        check("D idx skip addr", {20'b0, ram_addr}, 32'h802);
        check("D idx skip data", ram_dataIn,        32'h501F);
      end
    end
    clr_ovf = 1'b0;

    // Reset during the ECG write: write vanishes, nothing stale afterwards
    do_reset();
    emg_in = 32'h777;
    ecg_in = 32'h888;
    run_to(10); #2;
    check("E in ecg wEn",  {31'b0, ram_wEn},  32'd1);
    check("E in ecg addr", {20'b0, ram_addr}, 32'hA00);
    #1;
    reset = 1'b1;
    #1;
    check("E reset wEn",      {31'b0, ram_wEn},  32'd0);
    check("E reset wr_count", {16'b0, wr_count}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc   = 0;
    for (int c = 0; c <= 11; c++) begin
      run_to(c);
      #2;
      if (c < 9) check("E no stale write", {31'b0, ram_wEn}, 32'd0);
      if (c == 9) begin
        check("E first emg wEn",  {31'b0, ram_wEn},  32'd1);
        check("E first emg addr", {20'b0, ram_addr}, 32'h800);
        check("E first emg data", ram_dataIn,        32'h777);
      end
      if (c == 11) check("E wr_count", {16'b0, wr_count}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/adc_ram_scheduler.md
# adc_ram_scheduler

Schedules EMG/ECG sample storage into the shared processor data RAM port. It generates the sample-rate tick and captures both ADC channels on each tick into a small pending FIFO. It drains each entry as two RAM writes into per-channel ring buffers, only in cycles the CPU leaves the port idle. It sits between the processor's dmem signals, the ADC capture outputs and the single-port RAM, so CPU accesses are never stalled or corrupted.

## Interface
- SAMPLE_INTERVAL, 175000: clocks between sample ticks (200 Hz at 35 MHz); must be ≥ 4.
- EMG_BASE, 12'h800: word address of EMG ring buffer.
- ECG_BASE, 12'hA00: word address of ECG ring buffer.
- BUF_DEPTH, 256: ring entries per channel; must be a power of two, ≤ 512.
- FIFO_DEPTH, 4: pending sample-pair entries; must be a power of two, ≥ 2.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- cpu_req  in  1  CPU accesses dmem this cycle (read or write).
- cpu_wEn  in  1  CPU write enable.
- cpu_addr  in  12  CPU word address.
- cpu_dataIn  in  32  CPU write data.
- emg_in  in  32  current EMG sample.
- ecg_in  in  32  current ECG sample.
- clr_ovf  in  1  single-cycle pulse; clears overflow.
- ram_wEn  out  1  RAM write enable.
- ram_addr  out  12  RAM word address.
- ram_dataIn  out  32  RAM write data.
- wr_count  out  16  completed sample pairs written; wraps mod 2^16.
- overflow  out  1  sticky; a tick found the FIFO full.
- drop_count  out  16  dropped ticks, saturating.

## Operation
- Timer: counts 0..SAMPLE_INTERVAL-1, then wraps. The cycle at terminal count is the tick.
- On a tick with FIFO not full:
  - push {emg_in, ecg_in, idx}, where idx is the 9-bit sample index mod BUF_DEPTH;
  - idx increments mod BUF_DEPTH.
- On a tick with FIFO full:
  - no push, idx unchanged;
  - overflow←1, drop_count increments, saturating at 16'hFFFF.
- Fullness uses pre-edge occupancy. A same-cycle pop does not make room, so the tick is dropped.
- Drain FSM states:
  - IDLE→WR_EMG when FIFO is non-empty.
  - WR_EMG→WR_ECG on a cycle with cpu_req=0.
  - WR_ECG→IDLE on a cycle with cpu_req=0; pops the head and increments wr_count.
  - In WR_* with cpu_req=1, the FSM holds its state and issues no write.
- Port mux:
  - cpu_req=1: ram_* = cpu_* exactly.
  - Else WR_EMG: ram_wEn=1, addr=EMG_BASE+idx, data=head.emg.
  - Else WR_ECG: ram_wEn=1, addr=ECG_BASE+idx, data=head.ecg.
  - Otherwise ram_wEn=0, ram_addr=cpu_addr, ram_dataIn=cpu_dataIn.
- Address add is 12-bit and truncates.
- clr_ovf clears overflow. If a drop occurs in the same cycle, overflow stays 1; set wins.
- Software finds the latest complete pair at index (wr_count-1) mod BUF_DEPTH.

## Timing
- Reset values:
  - Internal: timer=0, idx=0, FIFO empty, FSM IDLE.
  - Outputs: wr_count=0, overflow=0, drop_count=0.
  - ram_wEn=0 unless cpu_req·cpu_wEn, since CPU passthrough stays combinational.
- First tick occurs in cycle SAMPLE_INTERVAL-1 after reset deasserts.
- Samples are captured at the end of tick cycle T.
- With cpu_req=0 throughout:
  - FSM is IDLE in T+1.
  - EMG write in T+2.
  - ECG write in T+3.
  - wr_count update visible in T+4.
- Each cpu_req=1 cycle in WR_* delays the remaining writes by one cycle.
- Reset mid-drain: the FSM returns to IDLE immediately, pending entries are discarded, and no partial write completes after reset.
- FIFO push and pop in the same cycle are both allowed when not full; occupancy is unchanged.

## Configuration
- ADC_SCHED_DROP_CNT_EN defined: drop_count counts as specified.
- ADC_SCHED_DROP_CNT_EN undefined: drop_count is tied to 0 and its counter is removed. Overflow behaviour is unchanged.

## Test plan
- Idle CPU, SAMPLE_INTERVAL=8, emg_in=32'h111, ecg_in=32'h222 at the first tick (cycle 7) → write 0x111 @ 12'h800 in cycle 9, 0x222 @ 12'hA00 in cycle 10; wr_count=1 in cycle 11.
- cpu_req=1 with cpu_wEn=1, addr 12'h010, held for cycles 8–12 → ram_* mirror the CPU exactly; the EMG write lands in cycle 13, ECG in 14.
- BUF_DEPTH=4, CPU idle, 5 ticks → the fifth pair writes to 12'h800/12'hA00 again (wrap); wr_count=5.
- FIFO_DEPTH=2, cpu_req held 1, 3 ticks → overflow=1, drop_count=1, idx advanced by 2. Release → 2 pairs written. clr_ovf pulse → overflow=0.
- Reset asserted during WR_ECG → ram_wEn falls with reset; wr_count=0; after release no stale write occurs and the first tick lands in cycle SAMPLE_INTERVAL-1.
- Build without ADC_SCHED_DROP_CNT_EN, repeat the overflow test → overflow=1, drop_count=0.
